// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore sequencer for fetch/decode/execute/memory/writeback
// plus the R-type ALU function decoder feeding the shared 32-bit ALU.
module mips_mc_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] F,
    output logic [1:0] PCSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    state_e state_q, state_d;

    logic pc_write, branch, branch_ne, mem_write, ir_write, reg_write, illegal;

    // State register is the only storage in the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state and Moore outputs; F additionally depends on Funct in EXECUTE.
    always_comb begin
        state_d   = S_FETCH;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        F         = F_ADD;
        PCSrc     = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d  = S_DECODE;
                ir_write = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_ADDIEX;
                    OP_J:            state_d = S_JUMP;
                    default:         illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                state_d = S_ALUWB;
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100000: F = F_ADD;
                    6'b100010: F = F_SUB;
                    6'b100100: F = F_AND;
                    6'b100101: F = F_OR;
                    6'b101010: F = F_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                F         = F_SUB;
                PCSrc     = 2'b01;
                branch    = (Op == OP_BEQ);
                branch_ne = (Op == OP_BNE);
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 2'b10;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are held off while reset is asserted so an abandoned instruction never commits.
    assign PCEn     = reset_n & (pc_write | (branch & Zero) | (branch_ne & ~Zero));
    assign MemWrite = reset_n & mem_write;
    assign IRWrite  = reset_n & ir_write;
    assign RegWrite = reset_n & reg_write;
    assign Illegal  = reset_n & illegal;
    assign State    = 4'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed scenarios plus randomized instruction
// streams compared against a per-instruction state-sequence and control-table model.
module tb_mips_mc_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk;
    logic       reset_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] F;
    logic       Illegal;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    logic [5:0] legal_ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    logic [5:0] legal_fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] fn_f      [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    int exp_seq[$];
    logic mon_en  = 1'b0;
    logic mw_seen = 1'b0;

    logic [15:0] obs;
    assign obs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, F, PCSrc, Illegal};

    mips_mc_control dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .F(F), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge MemWrite) if (mon_en) mw_seen = 1'b1;

    function automatic bit op_legal(logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fn_index(logic [5:0] fn);
        foreach (legal_fn[i]) if (legal_fn[i] == fn) return i;
        return -1;
    endfunction

    // Visited states for one instruction, from the instruction's class.
    function automatic void mk_seq(logic [5:0] op);
        case (op)
            OP_LW:          exp_seq = {0, 1, 2, 3, 4};
            OP_SW:          exp_seq = {0, 1, 2, 5};
            OP_R:           exp_seq = {0, 1, 6, 7};
            OP_ADDI:        exp_seq = {0, 1, 9, 10};
            OP_BEQ, OP_BNE: exp_seq = {0, 1, 8};
            OP_J:           exp_seq = {0, 1, 11};
            default:        exp_seq = {0, 1};
        endcase
    endfunction

    // Control word expected in a given state, from the per-state output table.
    function automatic logic [15:0] exp_out(int st, logic [5:0] op, logic [5:0] fn, logic z);
        logic pcen = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] f = 3'b010;
        int fi;
        case (st)
            0:    begin pcen = 1; irw = 1; sb = 2'b01; end
            1:    begin sb = 2'b11; ill = !op_legal(op); end
            2, 9: begin sa = 1; sb = 2'b10; end
            3:    iord = 1;
            4:    begin rw = 1; m2r = 1; end
            5:    begin iord = 1; mw = 1; end
            6:    begin
                      sa = 1;
                      fi = fn_index(fn);
                      if (fi >= 0) f = fn_f[fi];
                      else ill = 1;
                  end
            7:    begin rw = 1; rd = 1; end
            8:    begin sa = 1; f = 3'b110; ps = 2'b01; pcen = (op == OP_BEQ) ? z : !z; end
            10:   rw = 1;
            11:   begin pcen = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, f, ps, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with the DUT in its first active FETCH.
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; Op = OP_LW; Funct = 6'd0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
        checks++; if ({PCEn, MemWrite, RegWrite, IRWrite, Illegal} !== 5'b0) begin
            failures++; $display("FAIL reset_enables got=%b exp=00000", {PCEn, MemWrite, RegWrite, IRWrite, Illegal}); end
        checks++; if ({ALUSrcB, F, PCSrc} !== 7'b01_010_00) begin
            failures++; $display("FAIL reset_fetch_sel got=%b exp=0101000", {ALUSrcB, F, PCSrc}); end
        reset_n = 1'b1;
        #1;
        checks++; if ({State, IRWrite, PCEn} !== {4'd0, 2'b11}) begin
            failures++; $display("FAIL release_fetch got=%b exp=000011", {State, IRWrite, PCEn}); end
        step();
        checks++; if (State !== 4'd1) begin failures++; $display("FAIL release_decode got=%0d exp=1", State); end
    endtask

    task automatic test_lw();
        int seq[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        Op = OP_LW; Funct = 6'd0; Zero = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++; if (State !== 4'(seq[k])) begin
                failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", k, State, seq[k]); end
            if (k == 2) begin
                checks++; if ({F, ALUSrcB} !== 5'b010_10) begin
                    failures++; $display("FAIL lw_memadr got=%b exp=01010", {F, ALUSrcB}); end
            end
            if (k == 4) begin
                checks++; if ({RegWrite, MemtoReg} !== 2'b11) begin
                    failures++; $display("FAIL lw_memwb got=%b exp=11", {RegWrite, MemtoReg}); end
            end
            step();
        end
    endtask

    task automatic test_rtype_sweep();
        for (int i = 0; i < 5; i++) begin
            do_reset();
            Op = OP_R; Funct = legal_fn[i]; Zero = 1'b0;
            step(); step();
            checks++; if ({State, F, Illegal} !== {4'd6, fn_f[i], 1'b0}) begin
                failures++; $display("FAIL rtype_exec[%0d] got=%b exp=%b", i, {State, F, Illegal}, {4'd6, fn_f[i], 1'b0}); end
            step();
            checks++; if ({State, RegDst, RegWrite} !== {4'd7, 2'b11}) begin
                failures++; $display("FAIL rtype_aluwb[%0d] got=%b exp=011111", i, {State, RegDst, RegWrite}); end
        end
    endtask

    task automatic test_branch();
        logic exp_pcen;
        for (int b = 0; b < 2; b++) begin
            for (int z = 0; z < 2; z++) begin
                do_reset();
                Op = (b == 0) ? OP_BEQ : OP_BNE; Funct = 6'd0;
                step(); step();
                Zero = 1'(z);
                #1;
                exp_pcen = (b == 0) ? 1'(z) : !1'(z);
                checks++; if ({State, PCEn, PCSrc} !== {4'd8, exp_pcen, 2'b01}) begin
                    failures++; $display("FAIL branch_b%0d_z%0d got=%b exp=%b", b, z, {State, PCEn, PCSrc}, {4'd8, exp_pcen, 2'b01}); end
                step();
                checks++; if (State !== 4'd0) begin
                    failures++; $display("FAIL branch_return_b%0d_z%0d got=%0d exp=0", b, z, State); end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        Op = 6'b111111; Funct = 6'd0; Zero = 1'b0;
        step();
        checks++; if ({State, Illegal} !== {4'd1, 1'b1}) begin
            failures++; $display("FAIL illegal_op_decode got=%b exp=00011", {State, Illegal}); end
        step();
        checks++; if ({State, Illegal} !== {4'd0, 1'b0}) begin
            failures++; $display("FAIL illegal_op_return got=%b exp=00000", {State, Illegal}); end
        do_reset();
        Op = OP_R; Funct = 6'b000000;
        step(); step();
        checks++; if ({State, Illegal, F} !== {4'd6, 1'b1, 3'b010}) begin
            failures++; $display("FAIL illegal_funct_exec got=%b exp=01101010", {State, Illegal, F}); end
        step();
        checks++; if ({State, Illegal, RegWrite} !== {4'd7, 1'b0, 1'b1}) begin
            failures++; $display("FAIL illegal_funct_aluwb got=%b exp=011101", {State, Illegal, RegWrite}); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        Op = OP_SW; Funct = 6'd0; Zero = 1'b0;
        mw_seen = 1'b0; mon_en = 1'b1;
        step(); step();
        checks++; if (State !== 4'd2) begin failures++; $display("FAIL midop_memadr got=%0d exp=2", State); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({State, MemWrite} !== {4'd0, 1'b0}) begin
            failures++; $display("FAIL midop_async got=%b exp=00000", {State, MemWrite}); end
        step();
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL midop_hold got=%0d exp=0", State); end
        reset_n = 1'b1;
        step();
        mon_en = 1'b0;
        checks++; if ({State, mw_seen} !== {4'd1, 1'b0}) begin
            failures++; $display("FAIL midop_no_write got=%b exp=00010", {State, mw_seen}); end
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) < 7) op = legal_ops[$urandom_range(0, 6)];
            else begin
                op = 6'($urandom);
                while (op_legal(op)) op = 6'($urandom);
            end
            fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
            mk_seq(op);
            for (int k = 0; k < exp_seq.size(); k++) begin
                Op = op; Funct = fn; Zero = 1'($urandom);
                #1;
                checks++; if (State !== 4'(exp_seq[k])) begin
                    failures++; $display("FAIL rand_state n=%0d op=%b k=%0d got=%0d exp=%0d", n, op, k, State, exp_seq[k]); end
                checks++; if (obs !== exp_out(exp_seq[k], op, fn, Zero)) begin
                    failures++; $display("FAIL rand_ctrl n=%0d op=%b fn=%b st=%0d got=%b exp=%b", n, op, fn, exp_seq[k], obs, exp_out(exp_seq[k], op, fn, Zero)); end
                @(posedge clk);
                #1;
            end
        end
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL rand_final got=%0d exp=0", State); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_sweep();
        test_branch();
        test_illegal();
        test_midop_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit that sits directly upstream of the 32-bit ALU. Each cycle it sequences fetch, decode, execute, memory and writeback and drives the ALU's 3-bit function code. It also drives every datapath enable and mux select. It is a Moore state machine plus a combinational ALU decoder, so one shared ALU and one shared memory can serve the whole datapath.

## Interface
- No parameters. Opcodes, funct codes and state encodings are fixed, as listed below.
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- Op  in  6  instruction[31:26], taken from the instruction register
- Funct  in  6  instruction[5:0]
- Zero  in  1  ALU result-equals-zero flag
- PCEn  out  1  PC register enable, computed as PCWrite | (Branch & Zero) | (BranchNE & ~Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load enable
- RegDst  out  1  write-register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B operand: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- F  out  3  ALU function code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- State  out  4  current state, for debug

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable; if ever present, next state is FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq/bne, ADDIEX for addi, JUMP for j.
  - DECODE→FETCH for any other opcode, with Illegal=1 in DECODE.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECUTE→ALUWB→FETCH.
  - ADDIEX→ADDIWB→FETCH.
  - BRANCH→FETCH.
  - JUMP→FETCH.
- Asserted outputs per state. Anything not listed is 0; F defaults to 010.
  - FETCH: IRWrite, PCWrite, ALUSrcB=01, F=010, PCSrc=00.
  - DECODE: ALUSrcB=11, F=010.
  - MEMADR and ADDIEX: ALUSrcA, ALUSrcB=10, F=010.
  - MEMRD: IorD.
  - MEMWB: RegWrite, MemtoReg.
  - MEMWR: IorD, MemWrite.
  - EXECUTE: ALUSrcA, ALUSrcB=00, F from the funct decoder.
  - ALUWB: RegWrite, RegDst.
  - ADDIWB: RegWrite.
  - BRANCH: ALUSrcA, F=110, PCSrc=01, with Branch (beq) or BranchNE (bne).
  - JUMP: PCWrite, PCSrc=10.
- Funct decoder, used only in EXECUTE:
  - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct→F=010, Illegal=1 in EXECUTE, and ALUWB still executes.
- PCEn is combinational from the state, Op and the current Zero.
- State is the only register.

## Timing
- Reset: reset_n low forces State=FETCH immediately, without waiting for clk.
- While reset_n is low, PCEn, MemWrite, IRWrite, RegWrite and Illegal are 0. The remaining outputs take their FETCH values.
- The first FETCH cycle with active enables is the first rising edge after reset_n deasserts.
- Reset asserted mid-instruction abandons it. No partial write occurs after reset_n falls.
- Outputs settle combinationally from State, Op, Funct and Zero within the same cycle. There is no output register.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Zero is sampled only in BRANCH, where it is the result of the subtraction performed that cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with Op=100011 → State=0 and PCEn=MemWrite=RegWrite=IRWrite=0. On release, next edge gives State=1.
- lw: Op=100011 → States 0,1,2,3,4,0. MEMWB has RegWrite=1 and MemtoReg=1. MEMADR has F=010 and ALUSrcB=10.
- R-type sweep: Op=0 with Funct=100000/100010/100100/100101/101010 → F in EXECUTE is 010/110/000/001/111 respectively, and ALUWB has RegDst=1.
- beq/bne: beq with Zero=1 → PCEn=1, PCSrc=01 in BRANCH. beq with Zero=0 → PCEn=0. bne inverts both cases.
- Illegal: Op=111111 → Illegal pulses in DECODE and State returns to 0 next cycle. Op=0 with Funct=000000 → Illegal pulses in EXECUTE and F=010.
- Mid-op reset: sw, with reset_n pulled low in MEMADR → State=0 asynchronously and MemWrite stays 0 throughout.
